// File: rtl/gol_pkg.sv
// -----------------------------------------------------------------------------
// gol_pkg
// Shared types for the 8x8 toroidal Game of Life generation sequencer.
//   ROW_W / NROWS : board geometry
//   row_t         : one board row, bit c = column c
//   board_t       : packed array of rows, index = row number
//   gen_state_t   : generation sequencer states
//   row_wrap      : modular row neighbour (r-1 or r+1 mod 8)
// -----------------------------------------------------------------------------
package gol_pkg;

    localparam int unsigned ROW_W = 8;
    localparam int unsigned NROWS = 8;

    typedef logic [ROW_W-1:0] row_t;
    typedef row_t [NROWS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } gen_state_t;

    // 3-bit arithmetic gives the toroidal row wrap for free.
    function automatic logic [2:0] row_wrap(input logic [2:0] r, input logic up);
        return up ? 3'(r + 3'd1) : 3'(r - 3'd1);
    endfunction

endpackage

// File: rtl/gol_period_timer.sv
// -----------------------------------------------------------------------------
// gol_period_timer
// Free-running modulo-PERIOD counter with enable. Counts 0..PERIOD-1 while
// i_en=1 and asserts o_tick for the single cycle in which the count sits at
// PERIOD-1 (the wrap cycle). Dropping i_en clears the count.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   i_en   : count enable
//   o_tick : one-cycle pulse at wrap
// -----------------------------------------------------------------------------
module gol_period_timer #(
    parameter int unsigned PERIOD = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned       CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tick    = i_en && w_at_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_en || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gol_gen_sequencer.sv
// -----------------------------------------------------------------------------
// gol_gen_sequencer
// Holds the committed board (cur) and a shadow next-state board (nxt). A
// generation walks the external row decoder through rows 0..7 (one per cycle)
// filling nxt, then commits nxt into cur in one cycle.
//   clk, reset           : clock, asynchronous active-high reset
//   run                  : enables periodic auto-step every GEN_PERIOD cycles
//   step                 : single-generation request
//   ld_valid/ld_ready    : row-load handshake (accepted only in IDLE)
//   ld_idx, ld_row       : row index / data written into cur
//   dec_in/dec_a/dec_b   : rows r, r-1, r+1 of cur to the decoder (0 unless COMPUTE)
//   dec_out              : decoder next-state row for row r
//   disp_addr, disp_bits : display scan address and cur row disp_addr[5:3]
//   busy                 : generation in progress
//   gen_count            : committed generations (wraps)
//   stable, extinct      : last commit unchanged / board all zero
// -----------------------------------------------------------------------------
module gol_gen_sequencer
    import gol_pkg::*;
#(
    parameter int unsigned GEN_PERIOD = 1_000_000,
    parameter int unsigned DISP_DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [2:0]       ld_idx,
    input  logic [ROW_W-1:0] ld_row,
    output logic [ROW_W-1:0] dec_in,
    output logic [ROW_W-1:0] dec_a,
    output logic [ROW_W-1:0] dec_b,
    input  logic [ROW_W-1:0] dec_out,
    output logic [5:0]       disp_addr,
    output logic [ROW_W-1:0] disp_bits,
    output logic             busy,
    output logic [15:0]      gen_count,
    output logic             stable,
    output logic             extinct
);

    gen_state_t  r_state, w_next_state;
    logic [2:0]  r_row;
    board_t      r_cur, r_nxt;
    logic        r_pending;
    logic [15:0] r_gen_count;
    logic        r_stable, r_extinct;
    logic [5:0]  r_disp_addr;

    logic        w_gen_tick, w_disp_tick;
    logic        w_req, w_load, w_start;
    board_t      w_cur_loaded;

    gol_period_timer #(.PERIOD(GEN_PERIOD)) u_gen_timer (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_en   (run),
        .o_tick (w_gen_tick)
    );

    gol_period_timer #(.PERIOD(DISP_DIV)) u_disp_div (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_en   (1'b1),
        .o_tick (w_disp_tick)
    );

    assign w_req = step | w_gen_tick;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next state / handshake outputs ----------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_start      = 1'b0;
        ld_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                ld_ready = 1'b1;
                busy     = 1'b0;
                w_load   = ld_valid;
                // A load in the same cycle wins; the request waits in pending.
                if (!ld_valid && (w_req || r_pending)) begin
                    w_start      = 1'b1;
                    w_next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_row == 3'd7) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Board as it will look after this cycle's load, for the extinct update.
    always_comb begin
        w_cur_loaded         = r_cur;
        w_cur_loaded[ld_idx] = ld_row;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row       <= '0;
            r_cur       <= '0;
            r_nxt       <= '0;
            r_gen_count <= '0;
            r_stable    <= 1'b0;
            r_extinct   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_cur[ld_idx] <= ld_row;
                        r_stable      <= 1'b0;
                        r_extinct     <= (w_cur_loaded == '0);
                    end
                    if (w_start) begin
                        r_row <= '0;
                    end
                end
                COMPUTE: begin
                    r_nxt[r_row] <= dec_out;
                    r_row        <= r_row + 3'd1;
                end
                COMMIT: begin
                    r_cur       <= r_nxt;
                    r_gen_count <= r_gen_count + 16'd1;
                    r_stable    <= (r_nxt == r_cur);
                    r_extinct   <= (r_nxt == '0);
                end
                default: begin
                    r_row <= '0;
                end
            endcase
        end
    end

    // One-deep request latch: any request outside IDLE (or colliding with a
    // load) is remembered until the next start consumes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_load && w_req) begin
                r_pending <= 1'b1;
            end
        end else if (w_req) begin
            r_pending <= 1'b1;
        end
    end

    // ---------------- Display scan ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_addr <= '0;
        end else if (w_disp_tick) begin
            r_disp_addr <= r_disp_addr + 6'd1;
        end
    end

    // ---------------- Decoder feed ----------------
    always_comb begin
        dec_in = '0;
        dec_a  = '0;
        dec_b  = '0;
        if (r_state == COMPUTE) begin
            dec_in = r_cur[r_row];
            dec_a  = r_cur[row_wrap(r_row, 1'b0)];
            dec_b  = r_cur[row_wrap(r_row, 1'b1)];
        end
    end

    assign disp_addr = r_disp_addr;
    assign disp_bits = r_cur[r_disp_addr[5:3]];
    assign gen_count = r_gen_count;
    assign stable    = r_stable;
    assign extinct   = r_extinct;

endmodule
